jtopl_tick_timers: RTL and testbench

- Consumer end of the prescaler tick stream; twin OPL-style Timer A / Timer B.
- Counts qualified tick strobes into two 8-bit up-counters.
- Each counter reloads from a programmed value on overflow, sets a status flag and drives an active-low IRQ.
- Sits between the clock divider's `cen16`-class strobe and the register/status interface; the overflow pulses also feed CSM key-on logic.

---
 rtl/jtopl_tick_timers.sv | 66 ++++++
 tb/tb_jtopl_tick_timers.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/jtopl_tick_timers.sv
// jtopl_tick_timers: OPL-style Timer A/B tick counters with reload, flags and IRQ.
// Ports: clk, rst_n (async active-low); tick (qualified strobe);
//   value_a/value_b reload values; load_a/load_b run levels (rising edge loads);
//   mask_a/mask_b flag masks; clr_flags clears flags;
//   ovf_a/ovf_b one-clk overflow pulses; flag_a/flag_b sticky status; irq_n interrupt.
module jtopl_tick_timers #(
  parameter int W     = 8,
  parameter int BPRES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic [W-1:0] value_a,
  input  logic [W-1:0] value_b,
  input  logic         load_a,
  input  logic         load_b,
  input  logic         mask_a,
  input  logic         mask_b,
  input  logic         clr_flags,
  output logic         ovf_a,
  output logic         ovf_b,
  output logic         flag_a,
  output logic         flag_b,
  output logic         irq_n
);
  logic [W-1:0] cnt_a, cnt_b;
  logic [2:0]   pre;
  logic         load_a_q, load_b_q;
  logic         edge_a, edge_b, pre_end, adv_a, adv_b, wrap_a, wrap_b;
  // a load edge overrides a coincident tick, so advances are gated by ~edge
  assign edge_a  = load_a & ~load_a_q;
  assign edge_b  = load_b & ~load_b_q;
  assign pre_end = pre == 3'(BPRES - 1);
  assign adv_a   = tick & load_a & ~edge_a;
  assign adv_b   = tick & load_b & ~edge_b & pre_end;
  assign wrap_a  = adv_a & (&cnt_a);
  assign wrap_b  = adv_b & (&cnt_b);
  assign irq_n   = ~(flag_a | flag_b);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a    <= '0;
      cnt_b    <= '0;
      pre      <= '0;
      load_a_q <= 1'b0;
      load_b_q <= 1'b0;
      ovf_a    <= 1'b0;
      ovf_b    <= 1'b0;
      flag_a   <= 1'b0;
      flag_b   <= 1'b0;
    end else begin
      load_a_q <= load_a;
      load_b_q <= load_b;
      if (edge_a) cnt_a <= value_a;
      else if (adv_a) cnt_a <= wrap_a ? value_a : cnt_a + 1'b1;
      if (edge_b) cnt_b <= value_b;
      else if (adv_b) cnt_b <= wrap_b ? value_b : cnt_b + 1'b1;
      if (edge_b) pre <= '0;
      else if (tick & load_b) pre <= pre_end ? 3'd0 : pre + 3'd1;
      ovf_a  <= wrap_a;
      ovf_b  <= wrap_b;
      // an overflow in the same clk as clr_flags leaves the flag set
      flag_a <= (wrap_a & ~mask_a) | (flag_a & ~clr_flags);
      flag_b <= (wrap_b & ~mask_b) | (flag_b & ~clr_flags);
    end
  end
endmodule

// File: tb/tb_jtopl_tick_timers.sv
// tb_jtopl_tick_timers: directed and randomized checks against a behavioural timer model.
module tb_jtopl_tick_timers;
  localparam int W = 8, BPRES = 4, MAX = (1 << W) - 1;
  logic clk = 0, rst_n = 0, tick = 0, load_a = 0, load_b = 0, mask_a = 0, mask_b = 0, clr_flags = 0;
  logic [W-1:0] value_a = 0, value_b = 0;
  logic ovf_a, ovf_b, flag_a, flag_b, irq_n;
  int errs = 0, checks = 0;
  int m_a = 0, m_b = 0, m_pre = 0;
  bit la_q = 0, lb_q = 0, e_ovf_a = 0, e_ovf_b = 0, e_fa = 0, e_fb = 0;

  jtopl_tick_timers #(.W(W), .BPRES(BPRES)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .value_a(value_a), .value_b(value_b),
    .load_a(load_a), .load_b(load_b), .mask_a(mask_a), .mask_b(mask_b), .clr_flags(clr_flags),
    .ovf_a(ovf_a), .ovf_b(ovf_b), .flag_a(flag_a), .flag_b(flag_b), .irq_n(irq_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: A counts every tick while running; B counts every BPRES-th tick
  // since its start; each wraps from the top to the current reload value.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_a = 0; m_b = 0; m_pre = 0; la_q = 0; lb_q = 0;
      e_ovf_a = 0; e_ovf_b = 0; e_fa = 0; e_fb = 0;
    end else begin
      e_ovf_a = 0;
      e_ovf_b = 0;
      if (load_a && !la_q) m_a = value_a;
      else if (load_a && tick) begin
        if (m_a == MAX) begin m_a = value_a; e_ovf_a = 1; end
        else m_a = m_a + 1;
      end
      if (load_b && !lb_q) begin m_b = value_b; m_pre = 0; end
      else if (load_b && tick) begin
        m_pre = (m_pre + 1) % BPRES;
        if (m_pre == 0) begin
          if (m_b == MAX) begin m_b = value_b; e_ovf_b = 1; end
          else m_b = m_b + 1;
        end
      end
      la_q = load_a;
      lb_q = load_b;
      e_fa = (e_ovf_a && !mask_a) || (e_fa && !clr_flags);
      e_fb = (e_ovf_b && !mask_b) || (e_fb && !clr_flags);
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cyc_ovf_a", int'(ovf_a), int'(e_ovf_a));
    chk("cyc_ovf_b", int'(ovf_b), int'(e_ovf_b));
    chk("cyc_flag_a", int'(flag_a), int'(e_fa));
    chk("cyc_flag_b", int'(flag_b), int'(e_fb));
    chk("cyc_irq_n", int'(irq_n), int'(!(e_fa || e_fb)));
  end

  task automatic tk(input bit t);
    tick = t;
    @(negedge clk);
    tick = 0;
  endtask

  initial begin
    int n;
    logic [11:0] pat;
    repeat (2) @(negedge clk);
    chk("rst_ovf_a", int'(ovf_a), 0);
    chk("rst_flag_a", int'(flag_a), 0);
    chk("rst_irq_n", int'(irq_n), 1);
    rst_n = 1;
    // Timer A reload FE -> FF -> overflow
    value_a = 8'hFE; load_a = 1; tk(0);
    tk(1);
    chk("a_tick1_ovf", int'(ovf_a), 0);
    value_a = 8'h00;
    tk(1);
    chk("a_tick2_ovf", int'(ovf_a), 1);
    chk("a_tick2_flag", int'(flag_a), 1);
    chk("a_tick2_irq_n", int'(irq_n), 0);
    chk("model_ovf_a", int'(e_ovf_a), 1);
    tk(0);
    chk("a_ovf_one_clk", int'(ovf_a), 0);
    n = 0;
    for (int i = 0; i < 256; i++) begin
      tk(1);
      if (ovf_a) n++;
    end
    chk("a_256_count", n, 1);
    chk("a_256_last", int'(ovf_a), 1);
    // Timer B prescale
    value_b = 8'hFF; load_b = 1; tk(0);
    pat = '0;
    for (int k = 0; k < 12; k++) begin
      tk(1);
      pat[k] = ovf_b;
    end
    chk("b_pattern", int'(pat), 'h888);
    // Masking and clear
    load_b = 0; clr_flags = 1; tk(0); clr_flags = 0;
    chk("clr_flag_a", int'(flag_a), 0);
    chk("clr_flag_b", int'(flag_b), 0);
    value_a = 8'hFF; mask_a = 1; load_a = 0; tk(0); load_a = 1; tk(0);
    tk(1);
    chk("mask_ovf_a", int'(ovf_a), 1);
    chk("mask_flag_a", int'(flag_a), 0);
    chk("mask_irq_n", int'(irq_n), 1);
    mask_a = 0; tk(1);
    chk("unmask_flag_a", int'(flag_a), 1);
    clr_flags = 1; tk(0); clr_flags = 0;
    chk("clr2_flag_a", int'(flag_a), 0);
    chk("clr2_irq_n", int'(irq_n), 1);
    clr_flags = 1; tk(1); clr_flags = 0;
    chk("coinc_clr_flag_a", int'(flag_a), 1);
    // Load edge with coincident tick is not counted
    value_a = 8'hFE; load_a = 0; tk(0); load_a = 1;
    tk(1);
    chk("edge_tick_ovf0", int'(ovf_a), 0);
    tk(1);
    chk("edge_tick_ovf1", int'(ovf_a), 0);
    tk(1);
    chk("edge_tick_ovf2", int'(ovf_a), 1);
    // Hold
    value_a = 8'hFF; load_a = 0; n = 0;
    repeat (10) begin
      tk(1);
      if (ovf_a) n++;
    end
    chk("hold_no_ovf", n, 0);
    chk("hold_flag_a", int'(flag_a), 1);
    // Async reset between edges
    #2 rst_n = 0;
    #1;
    chk("arst_flag_a", int'(flag_a), 0);
    chk("arst_irq_n", int'(irq_n), 1);
    chk("arst_ovf_a", int'(ovf_a), 0);
    @(negedge clk);
    rst_n = 1; n = 0;
    repeat (5) begin
      tk(1);
      if (ovf_a || ovf_b || flag_a || flag_b) n++;
    end
    chk("post_rst_idle", n, 0);
    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 40 == 0) load_a = ~load_a;
      if ($urandom % 40 == 0) load_b = ~load_b;
      if ($urandom % 30 == 0) value_a = ($urandom % 2) ? 8'($urandom_range(8'hF0, 8'hFF)) : 8'($urandom);
      if ($urandom % 30 == 0) value_b = 8'($urandom_range(8'hF8, 8'hFF));
      if ($urandom % 60 == 0) mask_a = ~mask_a;
      if ($urandom % 60 == 0) mask_b = ~mask_b;
      clr_flags = ($urandom % 16) == 0;
      tick = $urandom % 2;
      if ($urandom % 700 == 0) begin
        #2 rst_n = 0;
        @(negedge clk);
        rst_n = 1;
      end else @(negedge clk);
    end
    tick = 0; clr_flags = 0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
